cr_rbus_initiator: RTL and testbench

- Register-bus ring master: turns a single-outstanding host request (read or write) into one ring transaction and injects it at the ring origin.
- Collects the transaction when it returns around the ring, then reports the returned data and a status to the host.
- Is the initiating end of the ring that every block register file (address-window responders) sits on.
- Used by chip-level config logic and by the standalone block benches to drive register traffic.

---
 rtl/cr_rbus_initiator.sv | 170 +++++++++++++++++
 tb/tb_cr_rbus_initiator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_rbus_initiator.sv
// cr_rbus_initiator: register-bus ring master at the ring origin.
// Accepts one host request at a time, injects it as a single-cycle ring
// strobe, waits for the same word to come back around the ring, and
// reports the returned data and a status to the host.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   host request handshake (req_wr, req_addr, req_wdata)
//   resp_valid/resp_ready host response handshake (resp_rdata, resp_status)
//   resp_status           00 ok, 01 nack (no responder claimed), 10 timeout
//   stray_cnt             saturating count of unexpected ring returns
//   ring_o_*              injected ring word (registered, never forwarded)
//   ring_i_*              returning ring word
module cr_rbus_initiator #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_status,

  output logic [7:0]        stray_cnt,

  output logic              ring_o_wr_strb,
  output logic              ring_o_rd_strb,
  output logic [ADDR_W-1:0] ring_o_addr,
  output logic [DATA_W-1:0] ring_o_wdata,
  output logic              ring_o_ack,
  output logic [DATA_W-1:0] ring_o_rdata,

  input  logic              ring_i_wr_strb,
  input  logic              ring_i_rd_strb,
  input  logic [ADDR_W-1:0] ring_i_addr,
  input  logic [DATA_W-1:0] ring_i_wdata,
  input  logic              ring_i_ack,
  input  logic [DATA_W-1:0] ring_i_rdata
);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic              cap_wr;
  logic [ADDR_W-1:0] cap_addr;
  logic [CNT_W-1:0]  cnt;

  logic ring_i_strb_c;
  logic type_match_c;
  logic ring_i_match_c;
  logic stray_c;
  logic timeout_hit_c;
  logic unused_c;

  // Returning write data is not needed: writes report no data.
  assign unused_c = ^{ring_i_wdata, 1'b0};

  // A return must carry our address and exactly our strobe type.
  assign ring_i_strb_c  = ring_i_wr_strb | ring_i_rd_strb;
  assign type_match_c   = cap_wr ? (ring_i_wr_strb & ~ring_i_rd_strb)
                                 : (ring_i_rd_strb & ~ring_i_wr_strb);
  assign ring_i_match_c = ring_i_strb_c && (ring_i_addr == cap_addr) && type_match_c;

  // Anything on the ring that is not the return we are waiting for.
  assign stray_c = ring_i_strb_c && !((state == S_WAIT) && ring_i_match_c);

  assign timeout_hit_c = (cnt == CNT_W'(TIMEOUT - 1));

  // Control FSM with registered host and ring outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cap_wr         <= 1'b0;
      cap_addr       <= '0;
      cnt            <= '0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_status    <= ST_OK;
      stray_cnt      <= 8'd0;
      ring_o_wr_strb <= 1'b0;
      ring_o_rd_strb <= 1'b0;
      ring_o_addr    <= '0;
      ring_o_wdata   <= '0;
      ring_o_ack     <= 1'b0;
      ring_o_rdata   <= '0;
    end else begin
      // Injected word lives for one cycle only.
      ring_o_wr_strb <= 1'b0;
      ring_o_rd_strb <= 1'b0;
      ring_o_addr    <= '0;
      ring_o_wdata   <= '0;
      ring_o_ack     <= 1'b0;
      ring_o_rdata   <= '0;

      if (stray_c && (stray_cnt != 8'hFF)) begin
        stray_cnt <= stray_cnt + 8'd1;
      end

      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            cap_wr         <= req_wr;
            cap_addr       <= req_addr;
            ring_o_wr_strb <= req_wr;
            ring_o_rd_strb <= ~req_wr;
            ring_o_addr    <= req_addr;
            ring_o_wdata   <= req_wdata;
            cnt            <= '0;
            req_ready      <= 1'b0;
            state          <= S_WAIT;
          end
        end

        S_WAIT: begin
          req_ready <= 1'b0;
          // A return on the timeout edge is reported as a normal return.
          if (ring_i_match_c) begin
            resp_rdata  <= (!cap_wr && ring_i_ack) ? ring_i_rdata : '0;
            resp_status <= ring_i_ack ? ST_OK : ST_NACK;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else if (timeout_hit_c) begin
            resp_rdata  <= '0;
            resp_status <= ST_TIMEOUT;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          // Response fields hold until the host takes them.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          req_ready  <= 1'b0;
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr_rbus_initiator.sv
// Bench for cr_rbus_initiator: a 3-stage ring with one address-window
// responder (0x0100..0x01FF), directed transactions, and a scoreboard of
// expected responses pushed at issue and popped at the response handshake.
module tb_cr_rbus_initiator;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RING_R  = 3;

  typedef struct packed {
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
  } word_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [1:0]        status;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_status;
  logic [7:0]        stray_cnt;
  logic              ring_o_wr_strb, ring_o_rd_strb, ring_o_ack;
  logic [ADDR_W-1:0] ring_o_addr;
  logic [DATA_W-1:0] ring_o_wdata, ring_o_rdata;
  logic              ring_i_wr_strb, ring_i_rd_strb, ring_i_ack;
  logic [ADDR_W-1:0] ring_i_addr;
  logic [DATA_W-1:0] ring_i_wdata, ring_i_rdata;

  always #5 clk = ~clk;

  cr_rbus_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_status(resp_status),
    .stray_cnt(stray_cnt),
    .ring_o_wr_strb(ring_o_wr_strb), .ring_o_rd_strb(ring_o_rd_strb),
    .ring_o_addr(ring_o_addr), .ring_o_wdata(ring_o_wdata),
    .ring_o_ack(ring_o_ack), .ring_o_rdata(ring_o_rdata),
    .ring_i_wr_strb(ring_i_wr_strb), .ring_i_rd_strb(ring_i_rd_strb),
    .ring_i_addr(ring_i_addr), .ring_i_wdata(ring_i_wdata),
    .ring_i_ack(ring_i_ack), .ring_i_rdata(ring_i_rdata)
  );

  // Ring model: responder in the first stage, then plain register stages.
  word_t ring_o_w, ring_i_w, inj_w;
  word_t stage [RING_R];
  logic  ring_break = 1'b0;
  logic  inj_en = 1'b0;

  assign ring_o_w = {ring_o_wr_strb, ring_o_rd_strb, ring_o_addr,
                     ring_o_wdata, ring_o_ack, ring_o_rdata};

  function automatic word_t respond(input word_t w);
    word_t r;
    r = w;
    if ((w.wr || w.rd) && (w.addr >= 16'h0100) && (w.addr <= 16'h01FF)) begin
      r.ack = 1'b1;
      if (w.rd) r.rdata = 32'hDEADBEEF;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    stage[0] <= respond(ring_o_w);
    for (int i = 1; i < int'(RING_R); i++) stage[i] <= stage[i-1];
  end

  assign ring_i_w = inj_en ? inj_w : (ring_break ? '0 : stage[RING_R-1]);
  assign ring_i_wr_strb = ring_i_w.wr;
  assign ring_i_rd_strb = ring_i_w.rd;
  assign ring_i_addr    = ring_i_w.addr;
  assign ring_i_wdata   = ring_i_w.wdata;
  assign ring_i_ack     = ring_i_w.ack;
  assign ring_i_rdata   = ring_i_w.rdata;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request; returns #1 after the acceptance edge.
  task automatic send(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    if (!req_ready) check({tag, "_req_ready_wait"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Injected word in the cycle after acceptance, then all-zero the next cycle.
  task automatic check_inject(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata);
    check({tag, "_inj_strb"}, 64'({ring_o_wr_strb, ring_o_rd_strb}), 64'({wr, ~wr}));
    check({tag, "_inj_addr"}, 64'(ring_o_addr), 64'(addr));
    check({tag, "_inj_wdata"}, 64'(ring_o_wdata), 64'(wdata));
    check({tag, "_inj_ack_rdata"}, 64'({ring_o_ack, ring_o_rdata}), 64'd0);
    tick();
    check({tag, "_inj_clear"}, 64'({ring_o_wr_strb, ring_o_rd_strb, ring_o_addr, ring_o_wdata}), 64'd0);
  endtask

  // Waits (bounded) for resp_valid; cyc counts edges since acceptance.
  task automatic wait_valid(input string tag, input int exp_lat, input int cyc0);
    int cyc;
    cyc = cyc0;
    while (!resp_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  // Pops the scoreboard, compares, and completes the response handshake.
  task automatic consume(input string tag);
    exp_t e;
    if (!resp_valid) return;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
    check({tag, "_status"}, 64'(resp_status), 64'(e.status));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] held_rdata;
    logic              saw_valid;

    inj_w = '{wr: 1'b0, rd: 1'b1, addr: 16'h0200, wdata: 32'h0, ack: 1'b1, rdata: 32'h0BAD0BAD};

    // Reset values
    repeat (3) tick();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp", 64'({resp_valid, resp_rdata, resp_status, stray_cnt}), 64'd0);
    check("rst_ring_o", 64'({ring_o_wr_strb, ring_o_rd_strb, ring_o_addr, ring_o_ack}), 64'd0);
    check("rst_ring_o_data", 64'({ring_o_wdata, ring_o_rdata}), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // Read an acking register
    sb_q.push_back('{rdata: 32'hDEADBEEF, status: 2'b00});
    send("rd100", 1'b0, 16'h0100, 32'h0);
    check_inject("rd100", 1'b0, 16'h0100, 32'h0);
    wait_valid("rd100", RING_R + 1, 1);
    consume("rd100");

    // Write: no data comes back
    sb_q.push_back('{rdata: 32'h0, status: 2'b00});
    send("wr104", 1'b1, 16'h0104, 32'h12345678);
    check_inject("wr104", 1'b1, 16'h0104, 32'h12345678);
    wait_valid("wr104", RING_R + 1, 1);
    consume("wr104");

    // Read outside every window: nack
    sb_q.push_back('{rdata: 32'h0, status: 2'b01});
    send("rd7f00", 1'b0, 16'h7F00, 32'h0);
    check_inject("rd7f00", 1'b0, 16'h7F00, 32'h0);
    wait_valid("rd7f00", RING_R + 1, 1);
    consume("rd7f00");

    // Broken ring: timeout after TIMEOUT wait cycles, late return is stray
    ring_break = 1'b1;
    sb_q.push_back('{rdata: 32'h0, status: 2'b10});
    send("tmo", 1'b0, 16'h0200, 32'h0);
    check_inject("tmo", 1'b0, 16'h0200, 32'h0);
    wait_valid("tmo", TIMEOUT, 1);
    consume("tmo");
    repeat (20) tick();
    inj_en = 1'b1;
    tick();
    inj_en = 1'b0;
    check("tmo_stray_cnt", 64'(stray_cnt), 64'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) saw_valid = 1'b1;
      tick();
    end
    check("tmo_no_second_resp", 64'(saw_valid), 64'd0);
    ring_break = 1'b0;

    // Host back-pressure on the response with a request pending
    sb_q.push_back('{rdata: 32'hDEADBEEF, status: 2'b00});
    send("hold", 1'b0, 16'h0100, 32'h0);
    check_inject("hold", 1'b0, 16'h0100, 32'h0);
    wait_valid("hold", RING_R + 1, 1);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 16'h0104;
    req_wdata = 32'h0;
    held_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      check("hold_stable",
            64'({resp_valid, resp_rdata, resp_status, req_ready, ring_o_rd_strb, ring_o_wr_strb}),
            64'({1'b1, held_rdata, 2'b00, 1'b0, 1'b0, 1'b0}));
      tick();
    end
    sb_q.push_back('{rdata: 32'hDEADBEEF, status: 2'b00});
    consume("hold");
    check("hold_ready_back", 64'({req_ready, ring_o_rd_strb}), 64'({1'b1, 1'b0}));
    tick();
    req_valid = 1'b0;
    check_inject("hold_next", 1'b0, 16'h0104, 32'h0);
    wait_valid("hold_next", RING_R + 1, 1);
    consume("hold_next");

    // Reset while waiting; abandoned word returns as a stray
    send("rstw", 1'b0, 16'h0100, 32'h0);
    check("rstw_inj", 64'(ring_o_rd_strb), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_outputs",
          64'({req_ready, resp_valid, resp_status, stray_cnt, ring_o_wr_strb, ring_o_rd_strb, ring_o_ack}),
          64'd0);
    check("rstw_data", 64'({resp_rdata, ring_o_addr}), 64'd0);
    repeat (5) tick();
    check("rstw_stray", 64'({stray_cnt, resp_valid}), 64'({8'd1, 1'b0}));
    sb_q.push_back('{rdata: 32'hDEADBEEF, status: 2'b00});
    send("rstw_next", 1'b0, 16'h0100, 32'h0);
    check_inject("rstw_next", 1'b0, 16'h0100, 32'h0);
    wait_valid("rstw_next", RING_R + 1, 1);
    consume("rstw_next");
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
